sd_spi_card_responder: RTL and testbench

- Synthesizable SPI-mode SD card responder: the card end of the link driven by the team's SD host driver.
- Oversamples the host's SCLK/CS/MOSI in the CLOCK50 domain, decodes 48-bit command frames and returns R1/R3/R7 responses on MISO.
- Used as the bench and loopback target for host-side bring-up.
- Supports CMD0, CMD8, CMD55, ACMD41 and CMD58. Every other command is reported illegal.

---
 rtl/sd_spi_card_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: oversamples host SCLK/CS/MOSI in the CLOCK50
// domain, decodes 48-bit command frames and answers with R1/R3/R7.
module sd_spi_card_responder #(
    parameter int          INIT_CLKS      = 74,
    parameter int          NCR            = 1,
    parameter int          ACMD41_RETRIES = 2,
    parameter logic [31:0] OCR            = 32'h40FF8000
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        CMD_STB,
    output logic [5:0]  CMD_IDX,
    output logic [31:0] CMD_ARG,
    output logic        CRC_ERR,
    output logic        IN_IDLE
);

    localparam int ICW = $clog2(INIT_CLKS + 1);
    localparam int ACW = $clog2(ACMD41_RETRIES + 2);
    localparam int TXW = 8 * NCR + 40;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_CMD  = 2'd1;
    localparam logic [1:0] DECODE  = 2'd2;
    localparam logic [1:0] TX      = 2'd3;

    logic [1:0]     sclk_sync;
    logic [1:0]     cs_sync;
    logic [1:0]     mosi_sync;
    logic           sclk_prev;
    logic           sclk_s;
    logic           cs_s;
    logic           mosi_s;
    logic           rise;
    logic           fall;
    logic [ICW-1:0] init_cnt;
    logic           init_done;
    logic [2:0]     bit_cnt;
    logic [6:0]     rx_sr;
    logic [7:0]     rx_byte;
    logic           byte_done;

    logic [1:0]     state;
    logic [47:0]    frame;
    logic [2:0]     rx_cnt;
    logic [TXW-1:0] tx_sr;
    logic [3:0]     tx_cnt;
    logic [3:0]     tx_len;
    logic           in_idle;
    logic [ACW-1:0] acmd_cnt;
    logic           cmd55_flag;

    logic [5:0]     idx;
    logic [31:0]    arg;
    logic           crc_bad;
    logic           long_rsp;
    logic [7:0]     r1;
    logic [31:0]    payload;
    logic [39:0]    resp;
    logic           nxt_idle;
    logic [ACW-1:0] nxt_cnt;
    logic           nxt_flag;
    logic           end_bit_unused;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign rise      = sclk_s & ~sclk_prev;
    assign fall      = ~sclk_s & sclk_prev;
    assign init_done = (init_cnt == ICW'(INIT_CLKS));
    assign rx_byte   = {rx_sr, mosi_s};
    assign byte_done = rise & init_done & ~cs_s & (bit_cnt == 3'd7);

    assign idx            = frame[45:40];
    assign arg            = frame[39:8];
    assign end_bit_unused = frame[0];
    assign IN_IDLE        = in_idle;

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SCLK};
            cs_sync   <= {cs_sync[0], CS};
            mosi_sync <= {mosi_sync[0], MOSI};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            init_cnt <= '0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
        end else begin
            if (rise && cs_s && !init_done)
                init_cnt <= init_cnt + ICW'(1);
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (rise && init_done) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte[6:0];
            end
        end
    end

    // Command effects; the CRC is only enforced for CMD0 and CMD8.
    always_comb begin
        nxt_idle = in_idle;
        nxt_cnt  = acmd_cnt;
        nxt_flag = 1'b0;
        long_rsp = 1'b0;
        payload  = 32'hFFFF_FFFF;
        r1       = 8'h04 | {7'b0, in_idle};
        crc_bad  = ((idx == 6'd0) || (idx == 6'd8)) &&
                   (crc7(frame[47:8]) != frame[7:1]);
        if (crc_bad) begin
            r1 = 8'h08 | {7'b0, in_idle};
        end else begin
            case (idx)
                6'd0: begin
                    nxt_idle = 1'b1;
                    nxt_cnt  = '0;
                    r1       = 8'h01;
                end
                6'd8: begin
                    r1       = {7'b0, in_idle};
                    long_rsp = 1'b1;
                    payload  = {20'h0, arg[11:0]};
                end
                6'd55: begin
                    nxt_flag = 1'b1;
                    r1       = {7'b0, in_idle};
                end
                6'd41: begin
                    if (cmd55_flag) begin
                        if (acmd_cnt < ACW'(ACMD41_RETRIES)) begin
                            nxt_cnt = acmd_cnt + ACW'(1);
                            r1      = 8'h01;
                        end else begin
                            nxt_idle = 1'b0;
                            r1       = 8'h00;
                        end
                    end
                end
                6'd58: begin
                    r1       = {7'b0, in_idle};
                    long_rsp = 1'b1;
                    payload  = {~in_idle, OCR[30:0]};
                end
                default: ;
            endcase
        end
        resp = {r1, payload};
    end

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            state      <= RX_IDLE;
            frame      <= '0;
            rx_cnt     <= '0;
            tx_sr      <= '1;
            tx_cnt     <= '0;
            tx_len     <= '0;
            MISO       <= 1'b1;
            CMD_STB    <= 1'b0;
            CMD_IDX    <= '0;
            CMD_ARG    <= '0;
            CRC_ERR    <= 1'b0;
            in_idle    <= 1'b1;
            acmd_cnt   <= '0;
            cmd55_flag <= 1'b0;
        end else begin
            CMD_STB <= 1'b0;
            CRC_ERR <= 1'b0;
            if (cs_s || !init_done) begin
                state <= RX_IDLE;
                MISO  <= 1'b1;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (byte_done && rx_byte[7:6] == 2'b01) begin
                            frame  <= {40'h0, rx_byte};
                            rx_cnt <= 3'd1;
                            state  <= RX_CMD;
                        end
                    end
                    RX_CMD: begin
                        if (byte_done) begin
                            frame  <= {frame[39:0], rx_byte};
                            rx_cnt <= rx_cnt + 3'd1;
                            if (rx_cnt == 3'd5) state <= DECODE;
                        end
                    end
                    DECODE: begin
                        CMD_STB    <= 1'b1;
                        CMD_IDX    <= idx;
                        CMD_ARG    <= arg;
                        CRC_ERR    <= crc_bad;
                        in_idle    <= nxt_idle;
                        acmd_cnt   <= nxt_cnt;
                        cmd55_flag <= nxt_flag;
                        tx_sr      <= {{NCR{8'hFF}}, resp};
                        tx_cnt     <= '0;
                        tx_len     <= long_rsp ? 4'(NCR + 5) : 4'(NCR + 1);
                        state      <= TX;
                    end
                    default: begin
                        // Host bytes clocked in here are ignored.
                        if (fall) begin
                            MISO  <= tx_sr[TXW-1];
                            tx_sr <= {tx_sr[TXW-2:0], 1'b1};
                        end
                        if (byte_done) begin
                            tx_cnt <= tx_cnt + 4'd1;
                            if (tx_cnt == tx_len - 4'd1) begin
                                state <= RX_IDLE;
                                MISO  <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder acting as a mode-0 SPI host.
// SPI edges are offset from CLOCK50 edges so sampling never races the DUT.
module tb_sd_spi_card_responder;

    logic        CLOCK50;
    logic        RESET;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        CRC_ERR;
    logic        IN_IDLE;

    int          n_vec;
    int          n_err;
    int          stb_cnt;
    logic [5:0]  last_idx;
    logic [31:0] last_arg;
    logic        last_crc;
    logic        miso_all1;
    logic [7:0]  rsp [0:7];

    localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD0X  = 48'h40_0000_0000_00;
    localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_FF;
    localparam logic [47:0] F_ACMD41 = 48'h69_4000_0000_FF;
    localparam logic [47:0] F_CMD41  = 48'h69_0000_0000_FF;
    localparam logic [47:0] F_CMD17  = 48'h51_0000_0000_FF;
    localparam logic [47:0] F_CMD58  = 48'h7A_0000_0000_FF;

    sd_spi_card_responder dut (
        .CLOCK50 (CLOCK50),
        .RESET   (RESET),
        .SCLK    (SCLK),
        .CS      (CS),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .CMD_STB (CMD_STB),
        .CMD_IDX (CMD_IDX),
        .CMD_ARG (CMD_ARG),
        .CRC_ERR (CRC_ERR),
        .IN_IDLE (IN_IDLE)
    );

    initial begin
        CLOCK50 = 1'b0;
        forever #5 CLOCK50 = ~CLOCK50;
    end

    always @(negedge CLOCK50) begin
        if (CMD_STB) begin
            stb_cnt  = stb_cnt + 1;
            last_idx = CMD_IDX;
            last_arg = CMD_ARG;
            last_crc = CRC_ERR;
        end
    end

    task automatic xfer(input logic [7:0] d, output logic [7:0] r);
        for (int b = 7; b >= 0; b--) begin
            MOSI = d[b];
            #40;
            r[b] = MISO;
            miso_all1 = miso_all1 & MISO;
            SCLK = 1'b1;
            #40;
            SCLK = 1'b0;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        CS    = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b1;
        #50;
        RESET = 1'b0;
        #50;
    endtask

    task automatic init_clks(input int n);
        CS = 1'b1;
        for (int i = 0; i < n; i++) begin
            #40 SCLK = 1'b1;
            #40 SCLK = 1'b0;
        end
        #80;
    endtask

    task automatic do_cmd(input logic [47:0] f, input int nrd);
        logic [7:0] r;
        miso_all1 = 1'b1;
        CS = 1'b0;
        #80;
        for (int i = 0; i < 6; i++) xfer(f[47-8*i -: 8], r);
        for (int i = 0; i < nrd; i++) begin
            xfer(8'hFF, r);
            rsp[i] = r;
        end
        CS = 1'b1;
        #160;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL rst_miso got %b want 1", MISO); end
        n_vec++; if (CMD_STB !== 1'b0) begin n_err++; $display("FAIL rst_stb got %b want 0", CMD_STB); end
        n_vec++; if (CMD_IDX !== 6'd0) begin n_err++; $display("FAIL rst_idx got %h want 0", CMD_IDX); end
        n_vec++; if (CMD_ARG !== 32'd0) begin n_err++; $display("FAIL rst_arg got %h want 0", CMD_ARG); end
        n_vec++; if (CRC_ERR !== 1'b0) begin n_err++; $display("FAIL rst_crc got %b want 0", CRC_ERR); end
        n_vec++; if (IN_IDLE !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", IN_IDLE); end
    endtask

    task automatic test_no_init();
        int s0;
        do_reset();
        init_clks(40);
        s0 = stb_cnt;
        do_cmd(F_CMD0, 2);
        n_vec++; if (stb_cnt !== s0) begin n_err++; $display("FAIL noinit_stb got %0d want %0d", stb_cnt, s0); end
        n_vec++; if (miso_all1 !== 1'b1) begin n_err++; $display("FAIL noinit_miso got %b want 1", miso_all1); end
    endtask

    task automatic test_cmd0();
        int s0;
        do_reset();
        init_clks(80);
        s0 = stb_cnt;
        do_cmd(F_CMD0, 2);
        n_vec++; if (stb_cnt !== s0 + 1) begin n_err++; $display("FAIL cmd0_stb got %0d want %0d", stb_cnt, s0 + 1); end
        n_vec++; if (last_idx !== 6'd0) begin n_err++; $display("FAIL cmd0_idx got %h want 0", last_idx); end
        n_vec++; if (last_arg !== 32'd0) begin n_err++; $display("FAIL cmd0_arg got %h want 0", last_arg); end
        n_vec++; if (last_crc !== 1'b0) begin n_err++; $display("FAIL cmd0_crc got %b want 0", last_crc); end
        n_vec++; if (rsp[0] !== 8'hFF) begin n_err++; $display("FAIL cmd0_ncr got %h want ff", rsp[0]); end
        n_vec++; if (rsp[1] !== 8'h01) begin n_err++; $display("FAIL cmd0_r1 got %h want 01", rsp[1]); end
        n_vec++; if (IN_IDLE !== 1'b1) begin n_err++; $display("FAIL cmd0_idle got %b want 1", IN_IDLE); end
    endtask

    task automatic test_crc_cmd8();
        logic [7:0] exp8 [0:4];
        exp8 = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        do_cmd(F_CMD0X, 2);
        n_vec++; if (last_crc !== 1'b1) begin n_err++; $display("FAIL crcerr_flag got %b want 1", last_crc); end
        n_vec++; if (rsp[1] !== 8'h09) begin n_err++; $display("FAIL crcerr_r1 got %h want 09", rsp[1]); end
        do_cmd(F_CMD8, 6);
        n_vec++; if (last_idx !== 6'd8) begin n_err++; $display("FAIL cmd8_idx got %h want 08", last_idx); end
        n_vec++; if (last_arg !== 32'h1AA) begin n_err++; $display("FAIL cmd8_arg got %h want 1aa", last_arg); end
        n_vec++; if (last_crc !== 1'b0) begin n_err++; $display("FAIL cmd8_crc got %b want 0", last_crc); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (rsp[i+1] !== exp8[i]) begin
                n_err++;
                $display("FAIL cmd8_byte%0d got %h want %h", i, rsp[i+1], exp8[i]);
            end
        end
    endtask

    task automatic test_illegal_idle();
        do_cmd(F_CMD41, 2);
        n_vec++; if (rsp[1] !== 8'h05) begin n_err++; $display("FAIL bare41_r1 got %h want 05", rsp[1]); end
        do_cmd(F_CMD17, 2);
        n_vec++; if (rsp[1] !== 8'h05) begin n_err++; $display("FAIL cmd17_idle got %h want 05", rsp[1]); end
    endtask

    task automatic test_acmd41();
        logic [7:0] expa [0:2];
        logic [7:0] exp58 [0:4];
        expa  = '{8'h01, 8'h01, 8'h00};
        exp58 = '{8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
        for (int i = 0; i < 3; i++) begin
            do_cmd(F_CMD55, 2);
            n_vec++; if (rsp[1] !== 8'h01) begin n_err++; $display("FAIL cmd55_%0d got %h want 01", i, rsp[1]); end
            do_cmd(F_ACMD41, 2);
            n_vec++; if (rsp[1] !== expa[i]) begin n_err++; $display("FAIL acmd41_%0d got %h want %h", i, rsp[1], expa[i]); end
        end
        n_vec++; if (IN_IDLE !== 1'b0) begin n_err++; $display("FAIL acmd41_idle got %b want 0", IN_IDLE); end
        do_cmd(F_CMD58, 6);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (rsp[i+1] !== exp58[i]) begin
                n_err++;
                $display("FAIL cmd58_byte%0d got %h want %h", i, rsp[i+1], exp58[i]);
            end
        end
        do_cmd(F_CMD17, 2);
        n_vec++; if (rsp[1] !== 8'h04) begin n_err++; $display("FAIL cmd17_ready got %h want 04", rsp[1]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        CS = 1'b0;
        #80;
        for (int i = 0; i < 6; i++) xfer(F_CMD58[47-8*i -: 8], r);
        xfer(8'hFF, r);
        #40;
        n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL mid_r1msb got %b want 0", MISO); end
        RESET = 1'b1;
        #1;
        n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL mid_rst_miso got %b want 1", MISO); end
        n_vec++; if (IN_IDLE !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle got %b want 1", IN_IDLE); end
        #49;
        RESET = 1'b0;
        CS = 1'b1;
        #80;
    endtask

    task automatic test_cs_abort();
        logic [7:0] r;
        int s0;
        init_clks(80);
        s0 = stb_cnt;
        CS = 1'b0;
        #80;
        for (int i = 0; i < 3; i++) xfer(F_CMD8[47-8*i -: 8], r);
        CS = 1'b1;
        #160;
        do_cmd(F_CMD0, 2);
        n_vec++; if (stb_cnt !== s0 + 1) begin n_err++; $display("FAIL abort_stb got %0d want %0d", stb_cnt, s0 + 1); end
        n_vec++; if (last_idx !== 6'd0) begin n_err++; $display("FAIL abort_idx got %h want 0", last_idx); end
        n_vec++; if (rsp[1] !== 8'h01) begin n_err++; $display("FAIL abort_r1 got %h want 01", rsp[1]); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        stb_cnt   = 0;
        last_idx  = '0;
        last_arg  = '0;
        last_crc  = 1'b0;
        miso_all1 = 1'b1;
        RESET     = 1'b1;
        CS        = 1'b1;
        SCLK      = 1'b0;
        MOSI      = 1'b1;
        #2;
        test_reset();
        test_no_init();
        test_cmd0();
        test_crc_cmd8();
        test_illegal_idle();
        test_acmd41();
        test_reset_mid();
        test_cs_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
